// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: mode/data/burst controls in, register contents and status out.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       mode;
    logic             rot;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic             busy;
    logic             done;

    modport master (
        output mode, rot, sin_r, sin_l, d, start, cnt,
        input  q, so_r, so_l, busy, done
    );

    modport slave (
        input  mode, rot, sin_r, sin_l, d, start, cnt,
        output q, so_r, so_l, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / load each clock,
// plus a counted burst shift that runs on its own once started.
//
// state | meaning
// IDLE  | mode applied to q every clock; a valid start latches a burst
// BURST | one shift per clock with latched direction/rot; mode/d/start/cnt ignored
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_,
    univ_shift_reg_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic             dir_left_r;
    logic             rot_r;
    logic             done_r;
    logic             accept;
    logic             last_shift;
    logic             shift_r, shift_l, load, rot_sel, busy;

    assign accept     = (state == IDLE) && bus.start && bus.cnt != '0 &&
                        (bus.mode == 2'b01 || bus.mode == 2'b10);
    assign last_shift = (state == BURST) && (cnt_r == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = BURST;
            BURST:   if (last_shift) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_r = 1'b0;
        shift_l = 1'b0;
        load    = 1'b0;
        rot_sel = bus.rot;
        busy    = 1'b0;
        case (state)
            IDLE: begin
                // The start cycle of an accepted burst holds q.
                if (!accept) begin
                    shift_r = (bus.mode == 2'b01);
                    shift_l = (bus.mode == 2'b10);
                    load    = (bus.mode == 2'b11);
                end
            end
            BURST: begin
                shift_r = !dir_left_r;
                shift_l = dir_left_r;
                rot_sel = rot_r;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        q_nxt = q_r;
        if (load)
            q_nxt = bus.d;
        else if (shift_r)
            q_nxt = {(rot_sel ? q_r[0] : bus.sin_r), q_r[WIDTH-1:1]};
        else if (shift_l)
            q_nxt = {q_r[WIDTH-2:0], (rot_sel ? q_r[WIDTH-1] : bus.sin_l)};
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            q_r        <= '0;
            cnt_r      <= '0;
            dir_left_r <= 1'b0;
            rot_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            done_r <= last_shift;
            if (accept) begin
                cnt_r      <= bus.cnt;
                dir_left_r <= bus.mode[1];
                rot_r      <= bus.rot;
            end else if (state == BURST) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.so_r = q_r[0];
    assign bus.so_l = q_r[WIDTH-1];
    assign bus.busy = busy;
    assign bus.done = done_r;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8): directed scenarios plus random traffic
// checked against a behavioural model of the register and its burst countdown.
module tb_univ_shift_reg;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    exp_t sb[$];

    // Model state: register value, shifts still owed by a burst, burst direction/rot, done flag.
    logic [W-1:0] mq = '0;
    int           mrem = 0;
    logic         mleft = 1'b0;
    logic         mrot = 1'b0;
    logic         mdone = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] shifted(input logic [W-1:0] v, input logic left,
                                             input logic r, input logic sr, input logic sl);
        logic fill;
        if (left) begin
            fill = r ? v[W-1] : sl;
            return (v << 1) | W'(fill);
        end else begin
            fill = r ? v[0] : sr;
            return (v >> 1) | (W'(fill) << (W - 1));
        end
    endfunction

    task automatic model_reset();
        mq = '0; mrem = 0; mleft = 1'b0; mrot = 1'b0; mdone = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] mode, input logic r, input logic sr,
                              input logic sl, input logic [W-1:0] dv, input logic st,
                              input int c);
        mdone = 1'b0;
        if (mrem > 0) begin
            mq = shifted(mq, mleft, mrot, sr, sl);
            mrem--;
            if (mrem == 0) mdone = 1'b1;
        end else if (st && c != 0 && (mode == 2'd1 || mode == 2'd2)) begin
            mrem  = c;
            mleft = (mode == 2'd2);
            mrot  = r;
        end else begin
            case (mode)
                2'd1: mq = shifted(mq, 1'b0, r, sr, sl);
                2'd2: mq = shifted(mq, 1'b1, r, sr, sl);
                2'd3: mq = dv;
                default: ;
            endcase
        end
    endtask

    // Drive one cycle's inputs at the falling edge, push the expected post-edge state.
    task automatic step(input logic [1:0] mode, input logic r, input logic sr, input logic sl,
                        input logic [W-1:0] dv, input logic st, input int c);
        exp_t e;
        @(negedge clk);
        bus.mode = mode; bus.rot = r; bus.sin_r = sr; bus.sin_l = sl;
        bus.d = dv; bus.start = st; bus.cnt = 4'(c);
        model_step(mode, r, sr, sl, dv, st, c);
        e.q = mq; e.busy = (mrem > 0); e.done = mdone;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_q", 64'(bus.q), 64'(e.q));
            chk("sb_so_r", 64'(bus.so_r), 64'(e.q[0]));
            chk("sb_so_l", 64'(bus.so_l), 64'(e.q[W-1]));
            chk("sb_busy", 64'(bus.busy), 64'(e.busy));
            chk("sb_done", 64'(bus.done), 64'(e.done));
        end
    end

    initial begin
        bus.mode = 2'd0; bus.rot = 1'b0; bus.sin_r = 1'b0; bus.sin_l = 1'b0;
        bus.d = '0; bus.start = 1'b0; bus.cnt = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q", 64'(bus.q), 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'h0);
        chk("reset_done", 64'(bus.done), 64'h0);
        @(negedge clk);
        rst_ = 1'b1;

        // Parallel load
        step(2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 0);
        #1 chk("load_a5", 64'(bus.q), 64'hA5);
        chk("load_so_r", 64'(bus.so_r), 64'h1);
        chk("load_so_l", 64'(bus.so_l), 64'h1);

        // Rotate right then fill-left
        step(2'd3, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 0);
        step(2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0);
        #1 chk("rotr_c0", 64'(bus.q), 64'hC0);
        step(2'd2, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 0);
        #1 chk("shl_81", 64'(bus.q), 64'h81);

        // Rotate-left burst of 3
        step(2'd3, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 0);
        step(2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3);
        idle(3);
        #1 chk("burst3_q", 64'(bus.q), 64'h08);
        chk("burst3_done", 64'(bus.done), 64'h1);
        idle(1);

        // Fill-right burst of 8 with a stray start/mode mid-burst
        step(2'd3, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 0);
        step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8);
        idle(3);
        step(2'd3, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 2);
        idle(4);
        #1 chk("burst8_q", 64'(bus.q), 64'h00);
        chk("burst8_done", 64'(bus.done), 64'h1);

        // Back-to-back burst started in the done cycle, cnt > WIDTH
        step(2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10);
        idle(11);

        // start with cnt=0 is a plain shift
        step(2'd3, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 0);
        step(2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0);
        #1 chk("cnt0_q", 64'(bus.q), 64'hAD);
        chk("cnt0_busy", 64'(bus.busy), 64'h0);

        // Reset in the second burst cycle
        step(2'd3, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 0);
        step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5);
        idle(1);
        @(negedge clk);
        #2 rst_ = 1'b0;
        #1 chk("midrst_q", 64'(bus.q), 64'h0);
        chk("midrst_busy", 64'(bus.busy), 64'h0);
        model_reset();
        @(posedge clk);
        #1 chk("midrst_done", 64'(bus.done), 64'h0);
        @(negedge clk);
        rst_ = 1'b1;
        step(2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 0);
        #1 chk("postrst_load", 64'(bus.q), 64'h3C);
        idle(2);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
        end
        idle(20);

        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have local parameter CNT_W, default $clog2(WIDTH+1), width of the burst count.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 SHALL have port rot  input  1  when 1, shifts rotate instead of taking serial fill.
REQ-007 SHALL have port sin_r  input  1  serial fill into q[WIDTH-1] on right shift.
REQ-008 SHALL have port sin_l  input  1  serial fill into q[0] on left shift.
REQ-009 SHALL have port d  input  WIDTH  parallel load data.
REQ-010 SHALL have port start  input  1  request a multi-cycle burst shift.
REQ-011 SHALL have port cnt  input  CNT_W  number of shifts in a burst.
REQ-012 SHALL have port q  output  WIDTH  registered contents.
REQ-013 SHALL have port so_r  output  1  right serial out, equal to q[0].
REQ-014 SHALL have port so_l  output  1  left serial out, equal to q[WIDTH-1].
REQ-015 SHALL have port busy  output  1  high while a burst is in progress.
REQ-016 SHALL have port done  output  1  registered one-cycle pulse at burst completion.

Function
REQ-017 SHALL implement FSM states IDLE and BURST.
REQ-018 In IDLE with start=0, each clock SHALL apply mode to q:
- hold: q unchanged.
- right: q <= {rot ? q[0] : sin_r, q[WIDTH-1:1]}.
- left: q <= {q[WIDTH-2:0], rot ? q[WIDTH-1] : sin_l}.
- load: q <= d.
REQ-019 In IDLE, start=1 with mode 01/10 and cnt!=0 SHALL latch direction, rot and cnt, hold q that cycle, and go to BURST.
REQ-020 In IDLE, start=1 with mode 00/11 or cnt==0 SHALL be ignored as a burst request; mode applies as in REQ-018, and busy/done stay 0.
REQ-021 In BURST, q SHALL shift once per clock using the latched direction and rot.
- Fill bits SHALL be sampled live from sin_r/sin_l each cycle.
- Exactly cnt shifts SHALL occur; the first happens on the clock after the start cycle.
REQ-022 busy SHALL be 1 for exactly the cnt cycles spent in BURST and 0 otherwise.
REQ-023 After the last shift, the FSM SHALL return to IDLE and done SHALL be 1 for exactly the next cycle; mode is honoured again from that cycle.
REQ-024 In BURST, mode, d, start and cnt SHALL be ignored; a start during BURST SHALL neither restart nor extend the burst.
REQ-025 cnt > WIDTH SHALL be legal.
- Rotate wraps modulo WIDTH.
- Non-rotate leaves q made entirely of fill bits.
REQ-026 A start in the cycle done is high SHALL be accepted per REQ-019, giving back-to-back bursts.
REQ-027 so_r and so_l SHALL be continuous functions of q, with no extra register stage.

Reset
REQ-028 rst_=0 SHALL immediately, independent of clk, force q=0, busy=0, done=0, state IDLE and latched count 0.
REQ-029 Reset mid-burst SHALL abort the burst with no done pulse.
REQ-030 After rst_ deasserts, the block SHALL operate from the first rising clk edge.

Verification (WIDTH=8)
REQ-031 SHALL cover: mode=11, d=8'hA5, one clk -> q=8'hA5, so_r=1, so_l=1.
REQ-032 SHALL cover: q=8'h81, mode=01, rot=1, one clk -> q=8'hC0; then mode=10, rot=0, sin_l=1, one clk -> q=8'h81.
REQ-033 SHALL cover: q=8'h01, start=1, mode=10, rot=1, cnt=3 -> busy high 3 cycles, then q=8'h08 with done high one cycle.
REQ-034 SHALL cover: q=8'hFF, start, mode=01, rot=0, sin_r=0, cnt=8 -> q=8'h00 after 8 busy cycles; a start pulse mid-burst does not change busy length.
REQ-035 SHALL cover: start with cnt=0 and mode=01 -> single right shift, busy=0, done=0.
REQ-036 SHALL cover: rst_ low in 2nd burst cycle -> q=0, busy=0 at once, no done pulse; a later load of 8'h3C works normally.
